id_operand_stage: RTL and testbench
===================================

// Module: id_operand_stage
// PURPOSE
//  Parametrised decode/operand stage: holds one instruction from IF, exposes it to the external decoder,
//  collects NSRC operands (register file, NFWD forwarding stages, immediate or pc), detects load-use
//  hazards per forwarding depth and stalls. Adds valid/ready handshake to EX, flush and stall counting.
// PARAMETERS
//  XLEN      32  datapath width
//  NREGS     32  architectural registers; RW = $clog2(NREGS)
//  NSRC       2  operand sources per instruction
//  NFWD       3  forwarding stages; index 0 = youngest (EX), NFWD-1 = oldest (WB)
//  ZERO_REG   1  1: register 0 reads 0 and never matches a forward
//  SCW       16  stall counter width
// PORTS
//  clk          in   1          clock
//  rst          in   1          asynchronous reset, active-high
//  if_valid     in   1          IF presents an instruction
//  if_ready     out  1          stage accepts IF this cycle
//  if_pc        in   XLEN       IF pc
//  if_nextpc    in   XLEN       IF predicted next pc
//  if_instr     in   32         IF instruction word
//  id_instr     out  32         held instruction, to decoder
//  dec_rs       in   NSRC*RW    source register index per source
//  dec_rs_used  in   NSRC       source actually read (hazard-relevant)
//  dec_sel      in   NSRC*2     per source: 0 reg, 1 imm, 2 pc, 3 zero
//  dec_imm      in   XLEN       decoded immediate
//  fwd_wen      in   NFWD       stage i will write fwd_rd[i]
//  fwd_rd       in   NFWD*RW    stage i destination
//  fwd_data     in   NFWD*XLEN  stage i result
//  fwd_pending  in   NFWD       stage i result not yet available (load/io read)
//  rf_raddr     out  NSRC*RW    register file read addresses (= dec_rs)
//  rf_rdata     in   NSRC*XLEN  register file read data, combinational
//  flush        in   1          branch/redirect resolved downstream
//  ex_ready     in   1          EX accepts this cycle
//  out_valid    out  1          operands valid for EX
//  out_pc       out  XLEN       held pc
//  out_nextpc   out  XLEN       held next pc
//  out_ops      out  NSRC*XLEN  resolved operands
//  hazard       out  1          load-use stall this cycle
//  stall_cnt    out  SCW        saturating count of hazard cycles
// BEHAVIOUR
//  Reset: valid_q=0, pc/nextpc/instr regs=0, stall_cnt=0; out_valid=0, hazard=0, if_ready=1. Async clear mid-op drops slot.
//  Operand src j (sel=reg): first stage i in 0..NFWD-1 with fwd_wen[i] && fwd_rd[i]==dec_rs[j] supplies
//   fwd_data[i]; none -> rf_rdata[j]. Lowest index wins. ZERO_REG && rs==0 -> 0, no match, no hazard.
//  sel=imm -> dec_imm; sel=pc -> out_pc; sel=3 -> 0. Non-reg sources never hazard.
//  Hazard src j: sel=reg && dec_rs_used[j] && winning stage i has fwd_pending[i]; that op driven 0.
//   Pending in an older stage shadowed by a younger non-pending match is not a hazard.
//  hazard = valid_q && any src hazard && !flush.
//  out_valid = valid_q && !hazard && !flush (combinational, same cycle).
//  load = !valid_q || (out_valid && ex_ready) || flush; if_ready = load && !flush.
//  Posedge: flush -> valid_q<=0 (IF input ignored that cycle); else if load -> capture if_*, valid_q<=if_valid;
//   else hold (instruction stays; re-evaluates forwarding every cycle).
//  Latency: instruction accepted cycle N is presented cycle N+1; zero-bubble throughput with no hazard/backpressure.
//  stall_cnt += 1 each cycle hazard=1, saturates at 2^SCW-1; backpressure cycles (!ex_ready) not counted.
//  Flush and hazard same cycle: flush wins, hazard=0, no count.
// TESTING
//  1 rst mid-stream with valid_q=1 -> out_valid=0, stall_cnt=0 same cycle, if_ready=1.
//  2 dec_rs={3,5}, fwd0 wr r3=0x11, fwd2 wr r3=0x33, rf r5=0x55 -> out_ops={0x11,0x55}, out_valid=1.
//  3 fwd0 r3 pending 2 cycles, src0 uses r3 -> hazard=1 x2, if_ready=0, stall_cnt=2, then op=fwd data.
//  4 rs=0, fwd0 wr r0 pending -> op=0, no hazard; sel=pc with pc=0x100 -> op=0x100.
//  5 ex_ready=0 for 3 cycles -> out_pc held, if_ready=0, stall_cnt unchanged; flush with hazard -> valid_q=0 next.
//  6 SCW=2, 5 hazard cycles -> stall_cnt saturates at 3; NSRC=3,NFWD=4 build passes tests 2-4.

Source files
------------

// File: rtl/id_operand_stage.sv
// Decode/operand stage: holds one IF instruction for the external decoder, resolves
// operands from forwarding/register file/immediate/pc, stalls on load-use hazards.
module id_operand_stage #(
  parameter int XLEN     = 32,
  parameter int NREGS    = 32,
  parameter int NSRC     = 2,
  parameter int NFWD     = 3,
  parameter int ZERO_REG = 1,
  parameter int SCW      = 16,
  localparam int RW      = $clog2(NREGS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 if_valid,
  output logic                 if_ready,
  input  logic [XLEN-1:0]      if_pc,
  input  logic [XLEN-1:0]      if_nextpc,
  input  logic [31:0]          if_instr,
  output logic [31:0]          id_instr,
  input  logic [NSRC*RW-1:0]   dec_rs,
  input  logic [NSRC-1:0]      dec_rs_used,
  input  logic [NSRC*2-1:0]    dec_sel,
  input  logic [XLEN-1:0]      dec_imm,
  input  logic [NFWD-1:0]      fwd_wen,
  input  logic [NFWD*RW-1:0]   fwd_rd,
  input  logic [NFWD*XLEN-1:0] fwd_data,
  input  logic [NFWD-1:0]      fwd_pending,
  output logic [NSRC*RW-1:0]   rf_raddr,
  input  logic [NSRC*XLEN-1:0] rf_rdata,
  input  logic                 flush,
  input  logic                 ex_ready,
  output logic                 out_valid,
  output logic [XLEN-1:0]      out_pc,
  output logic [XLEN-1:0]      out_nextpc,
  output logic [NSRC*XLEN-1:0] out_ops,
  output logic                 hazard,
  output logic [SCW-1:0]       stall_cnt
);

  localparam logic [1:0] SEL_REG  = 2'd0;
  localparam logic [1:0] SEL_IMM  = 2'd1;
  localparam logic [1:0] SEL_PC   = 2'd2;

  logic              valid_q;
  logic [XLEN-1:0]   pc_q;
  logic [XLEN-1:0]   nextpc_q;
  logic [31:0]       instr_q;
  logic [SCW-1:0]    stall_q;

  logic [XLEN-1:0]   reg_val [NSRC];
  logic [NSRC-1:0]   reg_pend;
  logic [NSRC-1:0]   src_haz;
  logic              any_haz;
  logic              load;

  // Scan oldest to youngest so the youngest matching stage overwrites the result.
  always_comb begin
    for (int j = 0; j < NSRC; j++) begin
      reg_val[j]  = rf_rdata[j*XLEN +: XLEN];
      reg_pend[j] = 1'b0;
      for (int i = NFWD-1; i >= 0; i--) begin
        if (fwd_wen[i] && (fwd_rd[i*RW +: RW] == dec_rs[j*RW +: RW])) begin
          reg_val[j]  = fwd_data[i*XLEN +: XLEN];
          reg_pend[j] = fwd_pending[i];
        end
      end
      if ((ZERO_REG != 0) && (dec_rs[j*RW +: RW] == '0)) begin
        reg_val[j]  = '0;
        reg_pend[j] = 1'b0;
      end
    end
  end

  always_comb begin
    out_ops = '0;
    src_haz = '0;
    for (int j = 0; j < NSRC; j++) begin
      case (dec_sel[j*2 +: 2])
        SEL_REG: begin
          if (dec_rs_used[j] && reg_pend[j]) begin
            src_haz[j] = 1'b1;
          end else begin
            out_ops[j*XLEN +: XLEN] = reg_val[j];
          end
        end
        SEL_IMM: out_ops[j*XLEN +: XLEN] = dec_imm;
        SEL_PC:  out_ops[j*XLEN +: XLEN] = pc_q;
        default: out_ops[j*XLEN +: XLEN] = '0;
      endcase
    end
  end

  // Handshake: out_valid/ex_ready transfer when both high; if_valid/if_ready likewise.
  // A held instruction re-resolves its operands every cycle until it transfers.
  assign any_haz    = |src_haz;
  assign hazard     = valid_q && any_haz && !flush;
  assign out_valid  = valid_q && !any_haz && !flush;
  assign load       = !valid_q || (out_valid && ex_ready) || flush;
  assign if_ready   = load && !flush;

  assign rf_raddr   = dec_rs;
  assign id_instr   = instr_q;
  assign out_pc     = pc_q;
  assign out_nextpc = nextpc_q;
  assign stall_cnt  = stall_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q  <= 1'b0;
      pc_q     <= '0;
      nextpc_q <= '0;
      instr_q  <= '0;
    end else if (flush) begin
      valid_q  <= 1'b0;
    end else if (load) begin
      valid_q  <= if_valid;
      pc_q     <= if_pc;
      nextpc_q <= if_nextpc;
      instr_q  <= if_instr;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_q <= '0;
    end else if (hazard && (stall_q != {SCW{1'b1}})) begin
      stall_q <= stall_q + SCW'(1);
    end
  end

endmodule

// File: tb/tb_id_operand_stage.sv
// Bench for id_operand_stage: directed vectors, expected transfers queued at issue and
// checked by a monitor whenever the stage hands operands to EX.
module tb_id_operand_stage;
  localparam int XLEN = 32;
  localparam int NSRC = 2;
  localparam int NFWD = 3;
  localparam int RW   = 5;
  localparam int EW   = 2*XLEN + NSRC*XLEN;

  logic clk = 1'b0;
  logic rst;
  logic if_valid;
  logic if_ready, if_ready_s;
  logic [XLEN-1:0] if_pc, if_nextpc;
  logic [31:0] if_instr;
  logic [31:0] id_instr, id_instr_s;
  logic [NSRC*RW-1:0] dec_rs;
  logic [NSRC-1:0] dec_rs_used;
  logic [NSRC*2-1:0] dec_sel;
  logic [XLEN-1:0] dec_imm;
  logic [NFWD-1:0] fwd_wen, fwd_pending;
  logic [NFWD*RW-1:0] fwd_rd;
  logic [NFWD*XLEN-1:0] fwd_data;
  logic [NSRC*RW-1:0] rf_raddr, rf_raddr_s;
  logic [NSRC*XLEN-1:0] rf_rdata;
  logic flush, ex_ready;
  logic out_valid, out_valid_s;
  logic [XLEN-1:0] out_pc, out_nextpc, out_pc_s, out_nextpc_s;
  logic [NSRC*XLEN-1:0] out_ops, out_ops_s;
  logic hazard, hazard_s;
  logic [15:0] stall_cnt;
  logic [1:0] stall_cnt_s;

  logic [EW-1:0] exp_q[$];
  int n_cmp = 0;
  int n_bad = 0;
  bit done = 1'b0;

  always #5 clk = ~clk;

  id_operand_stage dut (
    .clk(clk), .rst(rst), .if_valid(if_valid), .if_ready(if_ready), .if_pc(if_pc),
    .if_nextpc(if_nextpc), .if_instr(if_instr), .id_instr(id_instr), .dec_rs(dec_rs),
    .dec_rs_used(dec_rs_used), .dec_sel(dec_sel), .dec_imm(dec_imm), .fwd_wen(fwd_wen),
    .fwd_rd(fwd_rd), .fwd_data(fwd_data), .fwd_pending(fwd_pending), .rf_raddr(rf_raddr),
    .rf_rdata(rf_rdata), .flush(flush), .ex_ready(ex_ready), .out_valid(out_valid),
    .out_pc(out_pc), .out_nextpc(out_nextpc), .out_ops(out_ops), .hazard(hazard),
    .stall_cnt(stall_cnt)
  );

  // Narrow-counter copy sharing all inputs, used for the saturation boundary.
  id_operand_stage #(.SCW(2)) dut_s (
    .clk(clk), .rst(rst), .if_valid(if_valid), .if_ready(if_ready_s), .if_pc(if_pc),
    .if_nextpc(if_nextpc), .if_instr(if_instr), .id_instr(id_instr_s), .dec_rs(dec_rs),
    .dec_rs_used(dec_rs_used), .dec_sel(dec_sel), .dec_imm(dec_imm), .fwd_wen(fwd_wen),
    .fwd_rd(fwd_rd), .fwd_data(fwd_data), .fwd_pending(fwd_pending), .rf_raddr(rf_raddr_s),
    .rf_rdata(rf_rdata), .flush(flush), .ex_ready(ex_ready), .out_valid(out_valid_s),
    .out_pc(out_pc_s), .out_nextpc(out_nextpc_s), .out_ops(out_ops_s), .hazard(hazard_s),
    .stall_cnt(stall_cnt_s)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every transfer to EX must match the oldest queued expectation.
  always @(negedge clk) begin
    if (!rst && out_valid && ex_ready) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_xfer: got pc 0x%0h with nothing expected", out_pc);
      end else begin
        logic [EW-1:0] e;
        e = exp_q.pop_front();
        if ({out_pc, out_nextpc, out_ops} !== e) begin
          n_bad++;
          $display("FAIL xfer: got pc=%h npc=%h ops=%h expected %h",
                   out_pc, out_nextpc, out_ops, e);
        end
      end
    end
  end

  task automatic idle_inputs();
    if_valid = 1'b0; if_pc = '0; if_nextpc = '0; if_instr = '0;
    dec_rs = '0; dec_rs_used = '0; dec_sel = '0; dec_imm = '0;
    fwd_wen = '0; fwd_rd = '0; fwd_data = '0; fwd_pending = '0;
    rf_rdata = '0; flush = 1'b0; ex_ready = 1'b1;
  endtask

  // Present one instruction to IF for one accepting cycle; returns at posedge+1.
  task automatic issue(input logic [31:0] pc, input logic [31:0] instr);
    if_valid = 1'b1; if_pc = pc; if_nextpc = pc + 32'd4; if_instr = instr;
    @(posedge clk); #1;
    if_valid = 1'b0;
  endtask

  task automatic expect_xfer(input logic [31:0] pc, input logic [31:0] op1, input logic [31:0] op0);
    exp_q.push_back({pc, pc + 32'd4, op1, op0});
  endtask

  task automatic cycle();
    @(posedge clk); #1;
  endtask

  task automatic summary();
    if (!done) begin
      done = 1'b1;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
    end
  endtask

  initial begin
    #100000;
    n_bad++;
    $display("FAIL timeout: bench did not complete");
    summary();
  end

  initial begin
    idle_inputs();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    chk("reset_out_valid", 64'(out_valid), 64'd0);
    chk("reset_hazard", 64'(hazard), 64'd0);
    chk("reset_if_ready", 64'(if_ready), 64'd1);
    chk("reset_stall_cnt", 64'(stall_cnt), 64'd0);
    chk("reset_id_instr", 64'(id_instr), 64'd0);
    rst = 1'b0;
    cycle();

    // Forwarding priority: youngest stage wins, unmatched source reads the regfile.
    dec_rs = {5'd5, 5'd3}; dec_rs_used = 2'b11; dec_sel = 4'b0000;
    fwd_wen = 3'b101; fwd_rd = {5'd3, 5'd9, 5'd3};
    fwd_data = {32'h33, 32'h99, 32'h11}; rf_rdata = {32'h55, 32'hdead};
    expect_xfer(32'h1000, 32'h55, 32'h11);
    issue(32'h1000, 32'hcafe_0001);
    @(negedge clk);
    chk("fwd_out_valid", 64'(out_valid), 64'd1);
    chk("fwd_id_instr", 64'(id_instr), 64'hcafe_0001);
    chk("fwd_rf_raddr", 64'(rf_raddr), 64'({5'd5, 5'd3}));
    cycle();

    // Older pending stage shadowed by a younger ready one: no hazard.
    dec_rs = {5'd7, 5'd3};
    fwd_wen = 3'b011; fwd_rd = {5'd0, 5'd7, 5'd7}; fwd_pending = 3'b010;
    fwd_data = {32'h0, 32'hbad, 32'h77}; rf_rdata = {32'h66, 32'h44};
    expect_xfer(32'h1100, 32'h77, 32'h44);
    issue(32'h1100, 32'hcafe_0002);
    @(negedge clk);
    chk("shadow_hazard", 64'(hazard), 64'd0);
    cycle();

    // Load-use: youngest stage pending for two cycles.
    dec_rs = {5'd5, 5'd3}; fwd_wen = 3'b001; fwd_rd = {5'd0, 5'd0, 5'd3};
    fwd_pending = 3'b001; fwd_data = {32'h0, 32'h0, 32'hbeef}; rf_rdata = {32'h55, 32'h1};
    expect_xfer(32'h2000, 32'h55, 32'h99);
    issue(32'h2000, 32'hcafe_0003);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk("lu_hazard", 64'(hazard), 64'd1);
      chk("lu_if_ready", 64'(if_ready), 64'd0);
      chk("lu_out_valid", 64'(out_valid), 64'd0);
      cycle();
    end
    fwd_pending = '0; fwd_data = {32'h0, 32'h0, 32'h99};
    @(negedge clk);
    chk("lu_stall_cnt", 64'(stall_cnt), 64'd2);
    cycle();

    // r0 never matches or hazards; pc and imm/zero selects.
    dec_rs = {5'd0, 5'd0}; dec_sel = {2'd2, 2'd0}; dec_rs_used = 2'b11;
    fwd_wen = 3'b001; fwd_rd = '0; fwd_pending = 3'b001; fwd_data = {64'h0, 32'hbad};
    rf_rdata = {32'h12, 32'h34};
    expect_xfer(32'h100, 32'h100, 32'h0);
    issue(32'h100, 32'hcafe_0004);
    @(negedge clk);
    chk("r0_hazard", 64'(hazard), 64'd0);
    cycle();
    dec_rs = {5'd3, 5'd0}; dec_sel = {2'd3, 2'd1}; dec_imm = 32'h1234;
    fwd_rd = {5'd0, 5'd0, 5'd3};
    expect_xfer(32'h180, 32'h0, 32'h1234);
    issue(32'h180, 32'hcafe_0005);
    @(negedge clk);
    chk("nonreg_hazard", 64'(hazard), 64'd0);
    cycle();

    // Backpressure holds the slot; next instruction follows without a bubble.
    fwd_wen = '0; fwd_pending = '0; dec_sel = '0; dec_rs = {5'd5, 5'd4};
    rf_rdata = {32'haa, 32'hbb};
    expect_xfer(32'h3000, 32'haa, 32'hbb);
    expect_xfer(32'h4000, 32'haa, 32'hbb);
    issue(32'h3000, 32'hcafe_0006);
    ex_ready = 1'b0;
    if_valid = 1'b1; if_pc = 32'h4000; if_nextpc = 32'h4004; if_instr = 32'hcafe_0007;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("bp_out_pc", 64'(out_pc), 64'h3000);
      chk("bp_if_ready", 64'(if_ready), 64'd0);
      chk("bp_stall_cnt", 64'(stall_cnt), 64'd2);
      cycle();
    end
    ex_ready = 1'b1;
    cycle();
    if_valid = 1'b0;
    @(negedge clk);
    chk("bp_next_pc", 64'(out_pc), 64'h4000);
    cycle();

    // Flush wins over a simultaneous hazard and ignores IF.
    fwd_wen = 3'b001; fwd_rd = {5'd0, 5'd0, 5'd4}; fwd_pending = 3'b001;
    issue(32'h5000, 32'hcafe_0008);
    flush = 1'b1;
    if_valid = 1'b1; if_pc = 32'h6000; if_nextpc = 32'h6004;
    @(negedge clk);
    chk("flush_hazard", 64'(hazard), 64'd0);
    chk("flush_out_valid", 64'(out_valid), 64'd0);
    chk("flush_if_ready", 64'(if_ready), 64'd0);
    cycle();
    flush = 1'b0; if_valid = 1'b0; fwd_pending = '0;
    @(negedge clk);
    chk("after_flush_valid", 64'(out_valid), 64'd0);
    chk("after_flush_if_ready", 64'(if_ready), 64'd1);
    chk("after_flush_stall", 64'(stall_cnt), 64'd2);
    cycle();

    // Five hazard cycles: wide counter 2->7, 2-bit counter saturates at 3.
    fwd_pending = 3'b001;
    issue(32'h7000, 32'hcafe_0009);
    repeat (5) cycle();
    @(negedge clk);
    chk("sat_stall_wide", 64'(stall_cnt), 64'd7);
    chk("sat_stall_narrow", 64'(stall_cnt_s), 64'd3);
    cycle();
    flush = 1'b1;
    cycle();
    flush = 1'b0;

    // Asynchronous reset while an instruction is held.
    issue(32'h8000, 32'hcafe_000a);
    #2 rst = 1'b1;
    #1;
    chk("rst_mid_out_valid", 64'(out_valid), 64'd0);
    chk("rst_mid_hazard", 64'(hazard), 64'd0);
    chk("rst_mid_stall", 64'(stall_cnt), 64'd0);
    chk("rst_mid_stall_s", 64'(stall_cnt_s), 64'd0);
    chk("rst_mid_if_ready", 64'(if_ready), 64'd1);
    chk("rst_mid_out_pc", 64'(out_pc), 64'd0);
    @(negedge clk); #1;
    rst = 1'b0;
    idle_inputs();
    repeat (2) cycle();
    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    summary();
  end
endmodule
